// File: rtl/dma_pkg.sv
// Shared definitions for the DMA 4-bit memory channel endpoints.
//   MODE_*      : direction encoding of the descriptor mode bit
//   NIBBLE_W    : width of the nibble data port
//   port_state_e: FSM encoding of mem_nibble_port
package dma_pkg;

  localparam logic MODE_CPU_TO_MEM = 1'b1;
  localparam logic MODE_MEM_TO_CPU = 1'b0;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } port_state_e;

endpackage

// File: rtl/nibble_ram.sv
// Byte-wide RAM with nibble-granular writes and a backdoor port.
// Ports:
//   clk          : clock
//   i_nib_we     : per-nibble write enable, bit0 = [3:0], bit1 = [7:4]
//   i_addr       : data-path byte index
//   i_nib_wdata  : nibble written into the enabled half(s)
//   o_rdata      : asynchronous read of RAM[i_addr]
//   i_dbg_we     : backdoor byte write strobe
//   i_dbg_addr   : backdoor byte index
//   i_dbg_wdata  : backdoor write data
//   o_dbg_rdata  : asynchronous read of RAM[i_dbg_addr]
// Contents are never reset.
module nibble_ram
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic [1:0]          i_nib_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [NIBBLE_W-1:0] i_nib_wdata,
  output logic [7:0]          o_rdata,
  input  logic                i_dbg_we,
  input  logic [ADDR_W-1:0]   i_dbg_addr,
  input  logic [7:0]          i_dbg_wdata,
  output logic [7:0]          o_dbg_rdata
);

  logic [7:0] r_mem [DEPTH];

  // The backdoor write is issued first so that, on a same-byte collision,
  // the later nibble assignment overrides its half and the backdoor data
  // survives in the other half.
  always_ff @(posedge clk) begin
    if (i_dbg_we) begin
      r_mem[i_dbg_addr] <= i_dbg_wdata;
    end
    if (i_nib_we[0]) begin
      r_mem[i_addr][3:0] <= i_nib_wdata;
    end
    if (i_nib_we[1]) begin
      r_mem[i_addr][7:4] <= i_nib_wdata;
    end
  end

  assign o_rdata     = r_mem[i_addr];
  assign o_dbg_rdata = r_mem[i_dbg_addr];

endmodule

// File: rtl/mem_nibble_port.sv
// Memory-side endpoint of the DMA 4-bit memory channel.
// Accepts a descriptor (addr_in, len_in in nibbles, mode), then streams
// nibbles out of (mode 0) or into (mode 1) an internal byte RAM, low nibble
// of each byte first.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   address_in_valid/_enable            : descriptor handshake
//   addr_in, len_in, mode               : descriptor fields
//   mem_data_out, mem_to_dma_valid/_enable : read stream to DMA
//   mem_data_in, dma_to_mem_valid/_enable  : write stream from DMA
//   busy, xfer_done                     : status, done is a one-cycle pulse
//   dbg_we, dbg_addr, dbg_wdata, dbg_rdata : RAM backdoor
module mem_nibble_port
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                address_in_valid,
  output logic                address_in_enable,
  input  logic [31:0]         addr_in,
  input  logic [31:0]         len_in,
  input  logic                mode,
  output logic [NIBBLE_W-1:0] mem_data_out,
  output logic                mem_to_dma_valid,
  input  logic                mem_to_dma_enable,
  input  logic [NIBBLE_W-1:0] mem_data_in,
  input  logic                dma_to_mem_valid,
  output logic                dma_to_mem_enable,
  output logic                busy,
  output logic                xfer_done,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [7:0]          dbg_wdata,
  output logic [7:0]          dbg_rdata
);

  port_state_e       r_state, w_state_d;
  logic [ADDR_W-1:0] r_ptr, w_ptr_d;
  logic              r_half, w_half_d;
  logic [31:0]       r_rem, w_rem_d;
  logic              r_mode, w_mode_d;

  logic              w_hs;
  logic [1:0]        w_nib_we;
  logic [7:0]        w_rd_byte;

  // Only the low ADDR_W bits of the start address index the RAM.
  logic w_unused_addr;
  assign w_unused_addr = ^addr_in[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_half  <= 1'b0;
      r_rem   <= '0;
      r_mode  <= MODE_MEM_TO_CPU;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_half  <= w_half_d;
      r_rem   <= w_rem_d;
      r_mode  <= w_mode_d;
    end
  end

  always_comb begin
    w_state_d         = r_state;
    w_ptr_d           = r_ptr;
    w_half_d          = r_half;
    w_rem_d           = r_rem;
    w_mode_d          = r_mode;
    w_hs              = 1'b0;
    address_in_enable = 1'b0;
    mem_to_dma_valid  = 1'b0;
    dma_to_mem_enable = 1'b0;
    busy              = 1'b1;
    xfer_done         = 1'b0;

    unique case (r_state)
      StIdle: begin
        address_in_enable = 1'b1;
        busy              = 1'b0;
        if (address_in_valid) begin
          w_ptr_d  = addr_in[ADDR_W-1:0];
          w_half_d = 1'b0;
          w_rem_d  = len_in;
          w_mode_d = mode;
          if (len_in == 32'd0) begin
            w_state_d = StDone;
          end else if (mode == MODE_CPU_TO_MEM) begin
            w_state_d = StWr;
          end else begin
            w_state_d = StRd;
          end
        end
      end
      StRd: begin
        mem_to_dma_valid = 1'b1;
        w_hs             = mem_to_dma_enable;
      end
      StWr: begin
        dma_to_mem_enable = 1'b1;
        w_hs              = dma_to_mem_valid;
      end
      StDone: begin
        xfer_done = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Pointer/count advance is shared by both streaming directions.
    if (w_hs) begin
      w_rem_d = r_rem - 32'd1;
      if (r_half) begin
        w_ptr_d  = r_ptr + ADDR_W'(1);
        w_half_d = 1'b0;
      end else begin
        w_half_d = 1'b1;
      end
      if (r_rem == 32'd1) begin
        w_state_d = StDone;
      end
    end
  end

  // Nibble writes are suppressed in a reset cycle so an aborted transfer
  // leaves only the nibbles already handshaken.
  always_comb begin
    w_nib_we = 2'b00;
    if (!reset && r_state == StWr && dma_to_mem_valid) begin
      w_nib_we = r_half ? 2'b10 : 2'b01;
    end
  end

  assign mem_data_out = (r_state == StRd) ? (r_half ? w_rd_byte[7:4] : w_rd_byte[3:0])
                                          : '0;

  nibble_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk         (clk),
    .i_nib_we    (w_nib_we),
    .i_addr      (r_ptr),
    .i_nib_wdata (mem_data_in),
    .o_rdata     (w_rd_byte),
    .i_dbg_we    (dbg_we),
    .i_dbg_addr  (dbg_addr),
    .i_dbg_wdata (dbg_wdata),
    .o_dbg_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_mem_nibble_port.sv
module tb_mem_nibble_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        address_in_valid;
  logic        address_in_enable;
  logic [31:0] addr_in;
  logic [31:0] len_in;
  logic        mode;
  logic [3:0]  mem_data_out;
  logic        mem_to_dma_valid;
  logic        mem_to_dma_enable;
  logic [3:0]  mem_data_in;
  logic        dma_to_mem_valid;
  logic        dma_to_mem_enable;
  logic        busy;
  logic        xfer_done;
  logic        dbg_we;
  logic [7:0]  dbg_addr;
  logic [7:0]  dbg_wdata;
  logic [7:0]  dbg_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_nibble_port #(
    .DEPTH  (256),
    .ADDR_W (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address_in_valid  (address_in_valid),
    .address_in_enable (address_in_enable),
    .addr_in           (addr_in),
    .len_in            (len_in),
    .mode              (mode),
    .mem_data_out      (mem_data_out),
    .mem_to_dma_valid  (mem_to_dma_valid),
    .mem_to_dma_enable (mem_to_dma_enable),
    .mem_data_in       (mem_data_in),
    .dma_to_mem_valid  (dma_to_mem_valid),
    .dma_to_mem_enable (dma_to_mem_enable),
    .busy              (busy),
    .xfer_done         (xfer_done),
    .dbg_we            (dbg_we),
    .dbg_addr          (dbg_addr),
    .dbg_wdata         (dbg_wdata),
    .dbg_rdata         (dbg_rdata)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] len;
    logic [15:0] en;   // mem_to_dma_enable per RD cycle, bit 0 first
    logic [31:0] exp;  // expected nibbles, nibble k at [4k+3:4k]
  } rd_vec_t;

  rd_vec_t rv [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [7:0] a, input logic [7:0] d);
    dbg_we    = 1'b1;
    dbg_addr  = a;
    dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
  endtask

  task automatic dbg_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(name, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic run_read(input rd_vec_t v);
    int k;
    int cyc;
    check({v.name, " addr_en idle"}, 32'(address_in_enable), 32'd1);
    address_in_valid  = 1'b1;
    addr_in           = v.addr;
    len_in            = v.len;
    mode              = 1'b0;
    mem_to_dma_enable = 1'b0;
    tick();
    address_in_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < int'(v.len) && cyc < 64) begin
      mem_to_dma_enable = v.en[cyc % 16];
      check({v.name, " valid"}, 32'(mem_to_dma_valid), 32'd1);
      check({v.name, " data"}, 32'(mem_data_out), 32'(4'(v.exp >> (4 * k))));
      check({v.name, " no done"}, 32'(xfer_done), 32'd0);
      if (mem_to_dma_enable && mem_to_dma_valid) k++;
      tick();
      cyc++;
    end
    mem_to_dma_enable = 1'b0;
    check({v.name, " nibble count"}, 32'(k), v.len);
    check({v.name, " done pulse"}, 32'(xfer_done), 32'd1);
    check({v.name, " valid drop"}, 32'(mem_to_dma_valid), 32'd0);
    tick();
    check({v.name, " done once"}, 32'(xfer_done), 32'd0);
    check({v.name, " addr_en back"}, 32'(address_in_enable), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0] = '{"rd_basic", 32'h10,     32'd4, 16'hFFFF, 32'h3CA5};
    rv[1] = '{"rd_bp",    32'h10,     32'd4, 16'hFF59, 32'h3CA5};
    rv[2] = '{"rd_wrap",  32'hFF,     32'd4, 16'hFFFF, 32'h7E96};
    rv[3] = '{"rd_wrap2", 32'h1_00FF, 32'd4, 16'hFFFF, 32'h7E96};
    rv[4] = '{"rd_odd",   32'h10,     32'd3, 16'hFFFF, 32'h0CA5};

    reset             = 1'b1;
    address_in_valid  = 1'b0;
    addr_in           = '0;
    len_in            = '0;
    mode              = 1'b0;
    mem_to_dma_enable = 1'b0;
    mem_data_in       = '0;
    dma_to_mem_valid  = 1'b0;
    dbg_we            = 1'b0;
    dbg_addr          = '0;
    dbg_wdata         = '0;

    // Backdoor preload while reset is held.
    dbg_write(8'h10, 8'hA5);
    dbg_write(8'h11, 8'h3C);
    dbg_write(8'hFF, 8'h96);
    dbg_write(8'h00, 8'h7E);
    dbg_write(8'h20, 8'hFF);
    dbg_write(8'h21, 8'hFF);
    dbg_write(8'h30, 8'h00);
    dbg_write(8'h31, 8'h00);
    dbg_write(8'h40, 8'h00);

    check("rst addr_en", 32'(address_in_enable), 32'd1);
    check("rst valid", 32'(mem_to_dma_valid), 32'd0);
    check("rst wr_en", 32'(dma_to_mem_enable), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(xfer_done), 32'd0);
    check("rst data", 32'(mem_data_out), 32'd0);
    dbg_check("preload", 8'h10, 8'hA5);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_read(rv[i]);
    end

    // Odd-length write: high nibble of the last byte is untouched.
    address_in_valid = 1'b1;
    addr_in          = 32'h20;
    len_in           = 32'd3;
    mode             = 1'b1;
    tick();
    address_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wr enable", 32'(dma_to_mem_enable), 32'd1);
      check("wr no done", 32'(xfer_done), 32'd0);
      check("wr busy", 32'(busy), 32'd1);
      dma_to_mem_valid = 1'b1;
      mem_data_in      = 4'(i + 1);
      tick();
    end
    dma_to_mem_valid = 1'b0;
    check("wr done", 32'(xfer_done), 32'd1);
    check("wr enable drop", 32'(dma_to_mem_enable), 32'd0);
    tick();
    check("wr done once", 32'(xfer_done), 32'd0);
    dbg_check("wr byte0", 8'h20, 8'h21);
    dbg_check("wr byte1", 8'h21, 8'hF3);

    // Zero length: straight to DONE, no data valid.
    tick();
    address_in_valid = 1'b1;
    addr_in          = 32'h10;
    len_in           = 32'd0;
    mode             = 1'b0;
    tick();
    address_in_valid = 1'b0;
    check("zl done", 32'(xfer_done), 32'd1);
    check("zl valid", 32'(mem_to_dma_valid), 32'd0);
    check("zl busy", 32'(busy), 32'd1);
    tick();
    check("zl done once", 32'(xfer_done), 32'd0);
    check("zl addr_en", 32'(address_in_enable), 32'd1);

    // Second descriptor held during a read waits until the port is idle.
    address_in_valid  = 1'b1;
    addr_in           = 32'h10;
    len_in            = 32'd4;
    mode              = 1'b0;
    mem_to_dma_enable = 1'b0;
    tick();
    addr_in = 32'h11;
    len_in  = 32'd2;
    for (int i = 0; i < 3; i++) begin
      check("busy addr_en", 32'(address_in_enable), 32'd0);
      check("busy hold data", 32'(mem_data_out), 32'h5);
      tick();
    end
    mem_to_dma_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("busy rd data", 32'(mem_data_out), 32'(4'(32'h3CA5 >> (4 * i))));
      tick();
    end
    check("busy done", 32'(xfer_done), 32'd1);
    check("busy done addr_en", 32'(address_in_enable), 32'd0);
    tick();
    check("busy idle addr_en", 32'(address_in_enable), 32'd1);
    tick();
    address_in_valid = 1'b0;
    check("2nd valid", 32'(mem_to_dma_valid), 32'd1);
    check("2nd data0", 32'(mem_data_out), 32'hC);
    tick();
    check("2nd data1", 32'(mem_data_out), 32'h3);
    tick();
    mem_to_dma_enable = 1'b0;
    check("2nd done", 32'(xfer_done), 32'd1);
    tick();

    // Backdoor/nibble collision on the same byte.
    address_in_valid = 1'b1;
    addr_in          = 32'h40;
    len_in           = 32'd1;
    mode             = 1'b1;
    tick();
    address_in_valid = 1'b0;
    dma_to_mem_valid = 1'b1;
    mem_data_in      = 4'hD;
    dbg_we           = 1'b1;
    dbg_addr         = 8'h40;
    dbg_wdata        = 8'h5A;
    tick();
    dbg_we           = 1'b0;
    dma_to_mem_valid = 1'b0;
    check("coll done", 32'(xfer_done), 32'd1);
    dbg_check("coll merge", 8'h40, 8'h5D);
    tick();

    // Reset after 2 of 6 write nibbles.
    address_in_valid = 1'b1;
    addr_in          = 32'h30;
    len_in           = 32'd6;
    mode             = 1'b1;
    tick();
    address_in_valid = 1'b0;
    dma_to_mem_valid = 1'b1;
    mem_data_in      = 4'h1;
    tick();
    mem_data_in = 4'h2;
    tick();
    mem_data_in = 4'h3;
    reset       = 1'b1;
    tick();
    reset            = 1'b0;
    dma_to_mem_valid = 1'b0;
    check("abort addr_en", 32'(address_in_enable), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(xfer_done), 32'd0);
    check("abort wr_en", 32'(dma_to_mem_enable), 32'd0);
    check("abort valid", 32'(mem_to_dma_valid), 32'd0);
    check("abort data", 32'(mem_data_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no done", 32'(xfer_done), 32'd0);
    end
    dbg_check("abort byte0", 8'h30, 8'h21);
    dbg_check("abort byte1", 8'h31, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
